// File: rtl/bounce_sprite_engine.sv
// bounce_sprite_engine: N bouncing squares, per-frame synchronous position update, priority render to RGB222
// clk/reset: pixel clock, synchronous active-high reset
// frame_tick/pause: once-per-frame update request, pause freezes positions
// display_on/pix_x/pix_y: raster position from hvsync_generator
// rgb/overlap: registered pixel colour and multi-sprite flag, one cycle after pix_x/pix_y
// busy/bounce_count: update pass in progress, total wall reflections since reset
module bounce_sprite_engine #(
    parameter int NUM_SPRITES = 4,
    parameter int SIZE        = 64,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int POS_W       = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        pause,
    input  logic        display_on,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    output logic [5:0]  rgb,
    output logic        overlap,
    output logic        busy,
    output logic [15:0] bounce_count
);
    localparam int MAX_X = H_ACTIVE - SIZE;
    localparam int MAX_Y = V_ACTIVE - SIZE;
    localparam int IW = NUM_SPRITES > 1 ? $clog2(NUM_SPRITES) : 1;
    localparam logic [0:0] IDLE = 1'b0, UPDATE = 1'b1;
    typedef logic signed [POS_W+1:0] sw_t;
    logic [0:0] state;
    logic [IW-1:0] idx;
    logic [POS_W-1:0] x [NUM_SPRITES];
    logic [POS_W-1:0] y [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] dx, dy;
    sw_t nx, ny;
    logic hit_x, hit_y, last;
    logic [NUM_SPRITES-1:0] cov;
    logic [5:0] col;

    function automatic logic [5:0] pal(int i);
        logic [2:0] c;
        c = 3'((i % 7) + 1);
        return {{2{c[2]}}, {2{c[1]}}, {2{c[0]}}};
    endfunction

    // dx/dy set means moving toward 0; speeds are idx+2 (x) and idx+1 (y)
    always_comb begin
        nx = dx[idx] ? sw_t'(x[idx]) - sw_t'(idx) - sw_t'(2) : sw_t'(x[idx]) + sw_t'(idx) + sw_t'(2);
        ny = dy[idx] ? sw_t'(y[idx]) - sw_t'(idx) - sw_t'(1) : sw_t'(y[idx]) + sw_t'(idx) + sw_t'(1);
        hit_x = dx[idx] ? nx <= sw_t'(0) : nx >= sw_t'(MAX_X);
        hit_y = dy[idx] ? ny <= sw_t'(0) : ny >= sw_t'(MAX_Y);
        last = idx == IW'(NUM_SPRITES - 1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx <= '0;
            busy <= 1'b0;
            bounce_count <= '0;
            dx <= '0;
            dy <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                x[i] <= POS_W'((i * 128) % (MAX_X + 1));
                y[i] <= POS_W'((i * 96) % (MAX_Y + 1));
            end
        end else if (state == IDLE) begin
            state <= frame_tick && !pause ? UPDATE : IDLE;
            busy <= frame_tick && !pause;
            idx <= '0;
        end else begin
            x[idx] <= hit_x ? (dx[idx] ? '0 : POS_W'(MAX_X)) : nx[POS_W-1:0];
            y[idx] <= hit_y ? (dy[idx] ? '0 : POS_W'(MAX_Y)) : ny[POS_W-1:0];
            dx[idx] <= dx[idx] ^ hit_x;
            dy[idx] <= dy[idx] ^ hit_y;
            bounce_count <= bounce_count + 16'(hit_x) + 16'(hit_y);
            idx <= last ? '0 : idx + 1'b1;
            state <= last ? IDLE : UPDATE;
            busy <= !last;
        end
    end

    // Descending scan so the lowest-index covering sprite overwrites the colour last
    always_comb begin
        col = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            cov[i] = int'(pix_x) >= int'(x[i]) && int'(pix_x) < int'(x[i]) + SIZE &&
                     int'(pix_y) >= int'(y[i]) && int'(pix_y) < int'(y[i]) + SIZE;
            col = cov[i] ? pal(i) : col;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb <= '0;
            overlap <= 1'b0;
        end else begin
            rgb <= display_on ? col : '0;
            overlap <= display_on && (cov & (cov - 1'b1)) != '0;
        end
    end
endmodule
